// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between instruction fetch (IF,
// read only) and the data-memory stage (DM, load/store). One access is in
// flight at a time. DM has priority, but a streak limit guarantees that a
// waiting fetch is eventually served. Every output comes straight from a flop.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int RD_LAT        = 1,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction-fetch requester
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  // data-memory requester
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic              dm_valid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  // RAM macro
  output logic              ram_en_o,
  output logic              ram_rw_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_in_o,
  input  logic [DATA_W-1:0] ram_out_i,
  output logic              busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int SW = (MAX_DM_STREAK < 2) ? 1 : $clog2(MAX_DM_STREAK + 1);
  localparam int WW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);
  localparam logic [WW-1:0] WAIT_INIT  = WW'(RD_LAT);

  logic [1:0]        state_q,    state_d;
  logic              owner_dm_q, owner_dm_d;   // 1 = DM owns the access
  logic              we_q,       we_d;
  logic [SW-1:0]     streak_q,   streak_d;
  logic [WW-1:0]     wait_q,     wait_d;
  logic              if_ack_q,   if_ack_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              dm_ack_q,   dm_ack_d;
  logic              dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              ram_en_q,   ram_en_d;
  logic              ram_rw_q,   ram_rw_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_in_q,   ram_in_d;
  logic              busy_q,     busy_d;
  logic              grant_if;

  // Next-state logic: arbitration in IDLE, RAM sequencing in the other states.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d    = state_q;
    owner_dm_d = owner_dm_q;
    we_d       = we_q;
    streak_d   = streak_q;
    wait_d     = wait_q;
    if_ack_d   = 1'b0;
    if_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_ack_d   = 1'b0;
    dm_valid_d = 1'b0;
    dm_rdata_d = dm_rdata_q;
    ram_en_d   = 1'b0;
    ram_rw_d   = 1'b1;
    ram_addr_d = ram_addr_q;
    ram_in_d   = '0;
    grant_if   = if_req_i && (!dm_req_i || (streak_q == STREAK_MAX));

    case (state_q)
      S_IDLE: begin
        if (dm_req_i || if_req_i) begin
          state_d  = S_ISSUE;
          ram_en_d = 1'b1;
          if (grant_if) begin
            owner_dm_d = 1'b0;
            we_d       = 1'b0;
            ram_addr_d = if_addr_i;
            if_ack_d   = 1'b1;
            streak_d   = '0;
          end else begin
            owner_dm_d = 1'b1;
            we_d       = dm_we_i;
            ram_addr_d = dm_addr_i;
            ram_rw_d   = !dm_we_i;
            ram_in_d   = dm_we_i ? dm_wdata_i : '0;
            dm_ack_d   = 1'b1;
            // A DM win with fetch waiting means the streak is below the cap.
            if (!if_req_i)                    streak_d = '0;
            else if (streak_q != STREAK_MAX)  streak_d = streak_q + SW'(1);
          end
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d    = S_DONE;
          dm_valid_d = 1'b1;
        end else begin
          state_d = S_WAIT;
          wait_d  = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (wait_q == WW'(1)) begin
          state_d = S_DONE;
          if (owner_dm_q) begin
            dm_rdata_d = ram_out_i;
            dm_valid_d = 1'b1;
          end else begin
            if_rdata_d = ram_out_i;
            if_valid_d = 1'b1;
          end
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      default: begin  // S_DONE
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_dm_q <= 1'b0;
      we_q       <= 1'b0;
      streak_q   <= '0;
      wait_q     <= '0;
      if_ack_q   <= 1'b0;
      if_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_ack_q   <= 1'b0;
      dm_valid_q <= 1'b0;
      dm_rdata_q <= '0;
      ram_en_q   <= 1'b0;
      ram_rw_q   <= 1'b1;
      ram_addr_q <= '0;
      ram_in_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      owner_dm_q <= owner_dm_d;
      we_q       <= we_d;
      streak_q   <= streak_d;
      wait_q     <= wait_d;
      if_ack_q   <= if_ack_d;
      if_valid_q <= if_valid_d;
      if_rdata_q <= if_rdata_d;
      dm_ack_q   <= dm_ack_d;
      dm_valid_q <= dm_valid_d;
      dm_rdata_q <= dm_rdata_d;
      ram_en_q   <= ram_en_d;
      ram_rw_q   <= ram_rw_d;
      ram_addr_q <= ram_addr_d;
      ram_in_q   <= ram_in_d;
      busy_q     <= busy_d;
    end
  end

  assign if_ack_o   = if_ack_q;
  assign if_valid_o = if_valid_q;
  assign if_rdata_o = if_rdata_q;
  assign dm_ack_o   = dm_ack_q;
  assign dm_valid_o = dm_valid_q;
  assign dm_rdata_o = dm_rdata_q;
  assign ram_en_o   = ram_en_q;
  assign ram_rw_o   = ram_rw_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_in_o   = ram_in_q;
  assign busy_o     = busy_q;

endmodule
